// File: rtl/lock_pkg.sv
// lock_pkg: shared constants and types for the lock input datapath.
package lock_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam int NUM_DIGITS_DEF = 4;
  typedef enum logic {ENTRY, DONE} state_t;
endpackage

// File: rtl/digit_entry_encoder_edge_pulse.sv
// edge_pulse: one-bit rising-edge detector with synchronous reset.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);
  logic prev_q;
  always_ff @(posedge clk) prev_q <= rst ? 1'b0 : d_i;
  assign pulse_o = d_i & ~prev_q;
endmodule

// File: rtl/digit_entry_encoder.sv
// digit_entry_encoder: turns button edges into BCD digits and assembles a multi-digit code.
module digit_entry_encoder
  import lock_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_inc,
  input  logic                      btn_dec,
  input  logic                      btn_enter,
  input  logic                      btn_clear,
  output logic [DIGIT_W-1:0]        cur_digit,
  output logic [2:0]                digit_idx,
  output logic [4*NUM_DIGITS-1:0]   code,
  output logic                      code_valid
);
  logic [3:0] ev;
  logic inc, dec, ent, clr;
  state_t state_q, state_d;
  logic [DIGIT_W-1:0] cur_q, cur_d;
  logic [2:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] code_q, code_d;
  logic valid_q, valid_d;
  edge_pulse u_ep [3:0] (
    .clk     (clk),
    .rst     (rst),
    .d_i     ({btn_clear, btn_enter, btn_dec, btn_inc}),
    .pulse_o (ev)
  );
  assign {clr, ent, dec, inc} = ev;
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (state_q == DONE) begin
      state_d = ENTRY;
    end else if (clr) begin
      cur_d  = '0;
      idx_d  = '0;
      code_d = '0;
    end else if (ent) begin
      // first-entered digit lands in the most significant nibble
      for (int i = 0; i < NUM_DIGITS; i++)
        if (idx_q == 3'(NUM_DIGITS - 1 - i)) code_d[i*4 +: 4] = cur_q;
      cur_d = '0;
      if (idx_q == 3'(NUM_DIGITS - 1)) begin
        idx_d   = '0;
        state_d = DONE;
        valid_d = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else if (inc && !dec) begin
      cur_d = (cur_q == BCD_MAX) ? '0 : cur_q + 4'd1;
    end else if (dec && !inc) begin
      cur_d = (cur_q == '0) ? BCD_MAX : cur_q - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY;
      cur_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end
  assign cur_digit  = cur_q;
  assign digit_idx  = idx_q;
  assign code       = code_q;
  assign code_valid = valid_q;
endmodule

// File: tb/tb_digit_entry_encoder.sv
// tb_digit_entry_encoder: directed self-checking bench for digit_entry_encoder.
module tb_digit_entry_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_inc = 1'b0, btn_dec = 1'b0, btn_enter = 1'b0, btn_clear = 1'b0;
  logic [3:0] cur_digit;
  logic [2:0] digit_idx;
  logic [15:0] code;
  logic code_valid;
  int n_chk = 0;
  int n_fail = 0;

  digit_entry_encoder #(.NUM_DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_enter  (btn_enter),
    .btn_clear  (btn_clear),
    .cur_digit  (cur_digit),
    .digit_idx  (digit_idx),
    .code       (code),
    .code_valid (code_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_clear, btn_enter, btn_dec, btn_inc} = m;
  endtask

  task automatic press(input logic [3:0] m);
    set_btns(m);
    tick();
    set_btns(4'b0000);
    tick();
  endtask

  task automatic enter_digit(input int d);
    for (int i = 0; i < d; i++) press(4'b0001);
    press(4'b0100);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++; if (cur_digit !== 4'd0) begin n_fail++; $display("FAIL reset_cur got=%0d exp=0", cur_digit); end
    n_chk++; if (digit_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
    n_chk++; if (code !== 16'h0) begin n_fail++; $display("FAIL reset_code got=%h exp=0000", code); end
    n_chk++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
  endtask

  task automatic test_inc();
    for (int i = 1; i <= 3; i++) begin
      btn_inc = 1'b1;
      tick();
      n_chk++; if (cur_digit !== 4'(i)) begin n_fail++; $display("FAIL inc_step%0d got=%0d exp=%0d", i, cur_digit, i); end
      btn_inc = 1'b0;
      tick();
    end
    n_chk++; if (code !== 16'h0) begin n_fail++; $display("FAIL inc_code got=%h exp=0000", code); end
    n_chk++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL inc_valid got=%b exp=0", code_valid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) press(4'b0001);
    n_chk++; if (cur_digit !== 4'd9) begin n_fail++; $display("FAIL wrap_nine got=%0d exp=9", cur_digit); end
    press(4'b0001);
    n_chk++; if (cur_digit !== 4'd0) begin n_fail++; $display("FAIL wrap_inc got=%0d exp=0", cur_digit); end
    press(4'b0010);
    n_chk++; if (cur_digit !== 4'd9) begin n_fail++; $display("FAIL wrap_dec got=%0d exp=9", cur_digit); end
    press(4'b0011);
    n_chk++; if (cur_digit !== 4'd9) begin n_fail++; $display("FAIL incdec_same got=%0d exp=9", cur_digit); end
    press(4'b0010);
    n_chk++; if (cur_digit !== 4'd8) begin n_fail++; $display("FAIL dec_plain got=%0d exp=8", cur_digit); end
    press(4'b1000);
    n_chk++; if (cur_digit !== 4'd0) begin n_fail++; $display("FAIL clear_cur got=%0d exp=0", cur_digit); end
  endtask

  task automatic test_code_entry();
    enter_digit(1);
    enter_digit(2);
    enter_digit(3);
    n_chk++; if (code !== 16'h1230) begin n_fail++; $display("FAIL partial_code got=%h exp=1230", code); end
    n_chk++; if (digit_idx !== 3'd3) begin n_fail++; $display("FAIL partial_idx got=%0d exp=3", digit_idx); end
    for (int i = 0; i < 4; i++) press(4'b0001);
    btn_enter = 1'b1;
    tick();
    n_chk++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL done_valid got=%b exp=1", code_valid); end
    n_chk++; if (code !== 16'h1234) begin n_fail++; $display("FAIL done_code got=%h exp=1234", code); end
    n_chk++; if (digit_idx !== 3'd0) begin n_fail++; $display("FAIL done_idx got=%0d exp=0", digit_idx); end
    n_chk++; if (cur_digit !== 4'd0) begin n_fail++; $display("FAIL done_cur got=%0d exp=0", cur_digit); end
    btn_enter = 1'b0;
    tick();
    n_chk++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse got=%b exp=0", code_valid); end
    n_chk++; if (code !== 16'h1234) begin n_fail++; $display("FAIL code_hold got=%h exp=1234", code); end
  endtask

  task automatic test_clear();
    enter_digit(5);
    enter_digit(6);
    n_chk++; if (code !== 16'h5634) begin n_fail++; $display("FAIL overwrite_code got=%h exp=5634", code); end
    n_chk++; if (digit_idx !== 3'd2) begin n_fail++; $display("FAIL overwrite_idx got=%0d exp=2", digit_idx); end
    press(4'b0001);
    set_btns(4'b1100);
    tick();
    n_chk++; if (code !== 16'h0) begin n_fail++; $display("FAIL clr_code got=%h exp=0000", code); end
    n_chk++; if (digit_idx !== 3'd0) begin n_fail++; $display("FAIL clr_idx got=%0d exp=0", digit_idx); end
    n_chk++; if (cur_digit !== 4'd0) begin n_fail++; $display("FAIL clr_cur got=%0d exp=0", cur_digit); end
    n_chk++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got=%b exp=0", code_valid); end
    set_btns(4'b0000);
    tick();
    enter_digit(9);
    enter_digit(0);
    enter_digit(0);
    press(4'b0001);
    btn_enter = 1'b1;
    tick();
    n_chk++; if (code !== 16'h9001) begin n_fail++; $display("FAIL second_code got=%h exp=9001", code); end
    n_chk++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL second_valid got=%b exp=1", code_valid); end
    btn_enter = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    btn_inc = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    btn_inc = 1'b0;
    tick();
    n_chk++; if (cur_digit !== 4'd1) begin n_fail++; $display("FAIL hold_once got=%0d exp=1", cur_digit); end
    enter_digit(0);
    enter_digit(0);
    enter_digit(0);
    btn_enter = 1'b1;
    tick();
    n_chk++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL hold_done got=%b exp=1", code_valid); end
    n_chk++; if (code !== 16'h1000) begin n_fail++; $display("FAIL hold_code got=%h exp=1000", code); end
    btn_inc = 1'b1;
    tick();
    n_chk++; if (cur_digit !== 4'd0) begin n_fail++; $display("FAIL done_inc_lost got=%0d exp=0", cur_digit); end
    n_chk++; if (digit_idx !== 3'd0) begin n_fail++; $display("FAIL done_enter_idx got=%0d exp=0", digit_idx); end
    tick();
    n_chk++; if (cur_digit !== 4'd0) begin n_fail++; $display("FAIL done_not_queued got=%0d exp=0", cur_digit); end
    set_btns(4'b0000);
    tick();
  endtask

  task automatic test_rst_done();
    enter_digit(1);
    enter_digit(2);
    enter_digit(3);
    press(4'b0001);
    btn_enter = 1'b1;
    rst = 1'b1;
    tick();
    n_chk++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", code_valid); end
    n_chk++; if (code !== 16'h0) begin n_fail++; $display("FAIL rst_code got=%h exp=0000", code); end
    n_chk++; if (digit_idx !== 3'd0) begin n_fail++; $display("FAIL rst_idx got=%0d exp=0", digit_idx); end
    n_chk++; if (cur_digit !== 4'd0) begin n_fail++; $display("FAIL rst_cur got=%0d exp=0", cur_digit); end
    rst = 1'b0;
    btn_enter = 1'b0;
    tick();
    n_chk++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after got=%b exp=0", code_valid); end
    enter_digit(7);
    enter_digit(7);
    enter_digit(7);
    btn_enter = 1'b1;
    tick();
    n_chk++; if (code !== 16'h7770) begin n_fail++; $display("FAIL pre_rst_code got=%h exp=7770", code); end
    rst = 1'b1;
    tick();
    n_chk++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_done_valid got=%b exp=0", code_valid); end
    n_chk++; if (code !== 16'h0) begin n_fail++; $display("FAIL rst_in_done_code got=%h exp=0000", code); end
    rst = 1'b0;
    btn_enter = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_inc();
    test_wrap();
    test_code_entry();
    test_clear();
    test_hold();
    test_rst_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
